sram_master: RTL

//  Clocked FPGA-side initiator for the 8-bit asynchronous SRAM bus (nCS/nOE/nWE, 19-bit address).
//  - Turns single-word requests from internal logic (DMA, frame/capture engines) into SRAM cycles.
//  - Wait states are programmable; all SRAM strobes come from registers, so they are glitch-free.
//  - Sits on the SRAM pins in place of the ARM pass-through when the FPGA owns the memory.

---
 rtl/sram_master.sv | 132 +++++++++++++
 1 files changed

// File: rtl/sram_master.sv
// sram_master: clocked initiator for an 8-bit asynchronous SRAM.
// Strobes, address and bus enable all come straight from flops.
module sram_master #(
  parameter int AW       = 19,
  parameter int DW       = 8,
  parameter int RD_WAIT  = 2,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 2,
  parameter int WR_HOLD  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          ready,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  inout  wire  [DW-1:0] SRAM_D,
  output logic [AW-1:0] SRAM_A,
  output logic          SRAM_nCS,
  output logic          SRAM_nOE,
  output logic          SRAM_nWE
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    IDLE, RD, TURN, WSET, WPUL, WHLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] wdataQ;
  logic          driveQ;
  logic          prevRead;

  assign SRAM_D = driveQ ? wdataQ : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wdataQ      <= '0;
      driveQ      <= 1'b0;
      prevRead    <= 1'b0;
      ready       <= 1'b1;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      SRAM_A      <= '0;
      SRAM_nCS    <= 1'b1;
      SRAM_nOE    <= 1'b1;
      SRAM_nWE    <= 1'b1;
    end else begin
      rdata_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            SRAM_A <= addr;
            wdataQ <= wdata;
            ready  <= 1'b0;
            if (!we) begin
              state    <= RD;
              cnt      <= CW'(RD_WAIT);
              SRAM_nCS <= 1'b0;
              SRAM_nOE <= 1'b0;
            end else if (prevRead) begin
              // let the SRAM release the bus before we drive it
              state <= TURN;
            end else begin
              state    <= WSET;
              cnt      <= CW'(WR_SETUP - 1);
              SRAM_nCS <= 1'b0;
              driveQ   <= 1'b1;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            rdata       <= SRAM_D;
            rdata_valid <= 1'b1;
            SRAM_nCS    <= 1'b1;
            SRAM_nOE    <= 1'b1;
            ready       <= 1'b1;
            prevRead    <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        TURN: begin
          state    <= WSET;
          cnt      <= CW'(WR_SETUP - 1);
          SRAM_nCS <= 1'b0;
          driveQ   <= 1'b1;
        end
        WSET: begin
          if (cnt == '0) begin
            state    <= WPUL;
            cnt      <= CW'(WR_PULSE - 1);
            SRAM_nWE <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WPUL: begin
          if (cnt == '0) begin
            state    <= WHLD;
            cnt      <= CW'(WR_HOLD - 1);
            SRAM_nWE <= 1'b1;
            SRAM_nCS <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WHLD: begin
          if (cnt == '0) begin
            driveQ   <= 1'b0;
            ready    <= 1'b1;
            prevRead <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
